// File: rtl/mem_chk_pkg.sv
// Shared definitions for the memory read-data scoreboard.
package mem_chk_pkg;

    localparam int MAX_LATENCY = 30;

    localparam int DEF_AW  = 10;
    localparam int DEF_DW  = 32;
    localparam int DEF_CW  = 16;

endpackage

// File: rtl/mem_chk_dly.sv
// Fixed-depth delay line carrying captured read expectations to the compare point.
module mem_chk_dly
    import mem_chk_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    input  logic [DW-1:0] in_msk,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_exp,
    output logic [DW-1:0] out_msk
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
        logic [DW-1:0] msk;
    } entry_t;

    if (LATENCY == 0) begin : g_pass
        assign out_vld  = in_vld;
        assign out_addr = in_addr;
        assign out_exp  = in_exp;
        assign out_msk  = in_msk;
    end else begin : g_line
        logic   [LATENCY-1:0] vld;
        entry_t               data [LATENCY];

        // Only the valid bits are cleared; payload is don't-care when invalid.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld <= '0;
            end else begin
                vld[0] <= in_vld;
                for (int i = 1; i < LATENCY; i++)
                    vld[i] <= vld[i-1];
            end
        end

        always_ff @(posedge clk) begin
            data[0] <= '{addr: in_addr, exp: in_exp, msk: in_msk};
            for (int i = 1; i < LATENCY; i++)
                data[i] <= data[i-1];
        end

        assign out_vld  = vld[LATENCY-1];
        assign out_addr = data[LATENCY-1].addr;
        assign out_exp  = data[LATENCY-1].exp;
        assign out_msk  = data[LATENCY-1].msk;
    end

endmodule

// File: rtl/mem_rd_chk.sv
// Read-data scoreboard: shadows the write port, delays expected read data
// and compares it against the memory model's dout.
module mem_rd_chk
    import mem_chk_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read,
    input  logic [AW-1:0] addr_r,
    input  logic          write,
    input  logic [AW-1:0] addr_w,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] bw,
    input  logic [DW-1:0] dout,
    output logic          chk_vld,
    output logic          chk_err,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          sticky_err,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_exp,
    output logic [DW-1:0] first_err_got
);

    if (LATENCY >= MAX_LATENCY) begin : g_bad_latency
        $fatal(1, "mem_rd_chk: LATENCY %0d out of range", LATENCY);
    end

    localparam logic [AW:0] DEPTH = (AW+1)'(WORDS);

    logic [DW-1:0] shadow [WORDS];
    logic [DW-1:0] known  [WORDS];

    logic          rd_ok;
    logic          wr_ok;
    logic          h_vld;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_exp;
    logic [DW-1:0] h_msk;

    assign rd_ok = {1'b0, addr_r} < DEPTH;
    assign wr_ok = {1'b0, addr_w} < DEPTH;

    always_ff @(posedge clk) begin
        if (write && wr_ok)
            shadow[addr_w] <= (shadow[addr_w] & ~bw) | (din & bw);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++)
                known[i] <= '0;
        end else if (write && wr_ok) begin
            known[addr_w] <= known[addr_w] | bw;
        end
    end

    // Capture reads the arrays combinationally, i.e. before this cycle's write lands.
    mem_chk_dly #(
        .AW      (AW),
        .DW      (DW),
        .LATENCY (LATENCY)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (read && rd_ok),
        .in_addr  (addr_r),
        .in_exp   (shadow[addr_r]),
        .in_msk   (known[addr_r]),
        .out_vld  (h_vld),
        .out_addr (h_addr),
        .out_exp  (h_exp),
        .out_msk  (h_msk)
    );

    // Case inequality makes X/Z on a known bit a mismatch.
    assign chk_vld = rst && h_vld;
    assign chk_err = chk_vld && ((dout & h_msk) !== (h_exp & h_msk));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt         <= '0;
            err_cnt        <= '0;
            sticky_err     <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            if (chk_vld && rd_cnt != '1)
                rd_cnt <= rd_cnt + CW'(1);
            if (chk_err && err_cnt != '1)
                err_cnt <= err_cnt + CW'(1);
            if (chk_err && !sticky_err) begin
                sticky_err     <= 1'b1;
                first_err_addr <= h_addr;
                first_err_exp  <= h_exp;
                first_err_got  <= dout;
            end
        end
    end

    a_rd_range: assert property (
        @(posedge clk) disable iff (!rst) !(read && !rd_ok))
        else $error("ERROR: read address %0d out of range", addr_r);

    a_wr_range: assert property (
        @(posedge clk) disable iff (!rst) !(write && !wr_ok))
        else $error("ERROR: write address %0d out of range", addr_w);

endmodule

// File: tb/tb_mem_rd_chk.sv
// Randomized self-checking bench for mem_rd_chk against a queue-based model.
module tb_mem_rd_chk;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int WORDS = 16;
    localparam int LAT   = 3;
    localparam int CW    = 8;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr_r = '0;
    logic [AW-1:0] addr_w = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] bw = '0;
    logic [DW-1:0] dout = '0;
    logic          chk_vld;
    logic          chk_err;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] err_cnt;
    logic          sticky_err;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp;
    logic [DW-1:0] first_err_got;

    always #5 clk = ~clk;

    mem_rd_chk #(
        .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(LAT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .read(read), .addr_r(addr_r),
        .write(write), .addr_w(addr_w),
        .din(din), .bw(bw), .dout(dout),
        .chk_vld(chk_vld), .chk_err(chk_err),
        .rd_cnt(rd_cnt), .err_cnt(err_cnt),
        .sticky_err(sticky_err),
        .first_err_addr(first_err_addr),
        .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    typedef struct {
        bit          vld;
        int          addr;
        logic [DW-1:0] exp;
        logic [DW-1:0] msk;
        logic [DW-1:0] flip;
        bit          ovr_en;
        logic [DW-1:0] ovr;
    } ent_t;

    ent_t          pipe [$];
    ent_t          head;
    logic [DW-1:0] m_val   [WORDS];
    logic [DW-1:0] m_known [WORDS];
    int            m_rd, m_err;
    bit            m_sticky;
    int            m_faddr;
    logic [DW-1:0] m_fexp, m_fgot, m_fmsk;
    bit            exp_err;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        pipe.delete();
        head.vld = 0;
        m_rd = 0;
        m_err = 0;
        m_sticky = 0;
        for (int i = 0; i < WORDS; i++) m_known[i] = '0;
    endtask

    task automatic cycle(bit rd, int ra, bit wr, int wa,
                         logic [DW-1:0] d, logic [DW-1:0] b,
                         logic [DW-1:0] flip = '0,
                         bit ovr_en = 0, logic [DW-1:0] ovr = '0);
        ent_t e;
        logic [DW-1:0] rnd;
        @(posedge clk);
        #1;
        read = rd; addr_r = AW'(ra);
        write = wr; addr_w = AW'(wa);
        din = d; bw = b;
        e.vld = rd; e.addr = ra;
        e.exp = m_val[ra]; e.msk = m_known[ra];
        e.flip = flip; e.ovr_en = ovr_en; e.ovr = ovr;
        pipe.push_back(e);
        if (pipe.size() > LAT) head = pipe.pop_front();
        else head.vld = 0;
        rnd = $urandom;
        if (!head.vld) dout = rnd;
        else if (head.ovr_en) dout = head.ovr;
        else dout = ((head.exp & head.msk) | (rnd & ~head.msk)) ^ head.flip;
        exp_err = head.vld && (((dout ^ head.exp) & head.msk) != '0);
        @(negedge clk);
        check("chk_vld", chk_vld, head.vld);
        if (head.vld) check("chk_err", chk_err, exp_err);
        check("rd_cnt", rd_cnt, m_rd);
        check("err_cnt", err_cnt, m_err);
        check("sticky_err", sticky_err, m_sticky);
        if (m_sticky) begin
            check("first_err_addr", first_err_addr, m_faddr);
            check("first_err_exp", first_err_exp & m_fmsk, m_fexp & m_fmsk);
            check("first_err_got", first_err_got, m_fgot);
        end
        if (head.vld) begin
            if (m_rd < SAT) m_rd++;
            if (exp_err) begin
                if (m_err < SAT) m_err++;
                if (!m_sticky) begin
                    m_sticky = 1;
                    m_faddr = head.addr;
                    m_fexp = head.exp;
                    m_fmsk = head.msk;
                    m_fgot = dout;
                end
            end
        end
        if (wr) begin
            m_val[wa] = (m_val[wa] & ~b) | (d & b);
            m_known[wa] = m_known[wa] | b;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        read = 0; write = 0; rst = 0;
        model_clear();
        @(negedge clk);
        check("rst_chk_vld", chk_vld, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sticky", sticky_err, 0);
        check("rst_faddr", first_err_addr, 0);
        check("rst_fexp", first_err_exp, 0);
        check("rst_fgot", first_err_got, 0);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) m_val[i] = '0;
        model_clear();
        repeat (3) @(posedge clk);
        do_reset();

        // Basic write then read.
        cycle(0, 0, 1, 5, 32'hA5A5A5A5, '1);
        cycle(1, 5, 0, 0, '0, '0);
        idle(LAT);
        check("t1_vld", chk_vld, 1);
        check("t1_err", chk_err, 0);
        check("t1_model_exp", head.exp, 32'hA5A5A5A5);
        idle(1);
        check("t1_rd_cnt", rd_cnt, 1);

        // Corrupted return latches the first failure.
        cycle(1, 5, 0, 0, '0, '0, 32'h1);
        idle(LAT);
        check("t2_err", chk_err, 1);
        idle(1);
        check("t2_sticky", sticky_err, 1);
        check("t2_faddr", first_err_addr, 5);
        check("t2_fexp", first_err_exp, 32'hA5A5A5A5);
        check("t2_fgot", first_err_got, 32'hA5A5A5A4);
        check("t2_err_cnt", err_cnt, 1);

        // Same-cycle read and write sees the old value.
        cycle(0, 0, 1, 7, 32'h11, '1);
        cycle(1, 7, 1, 7, 32'h22, '1);
        cycle(1, 7, 0, 0, '0, '0);
        idle(LAT - 1);
        check("t3_old_exp", head.exp, 32'h11);
        check("t3_old_err", chk_err, 0);
        idle(1);
        check("t3_new_exp", head.exp, 32'h22);
        check("t3_new_err", chk_err, 0);

        // Partially written word: unknown bits are not checked.
        cycle(0, 0, 1, 9, 32'h1234ABCD, 32'h0000FFFF);
        cycle(1, 9, 0, 0, '0, '0, '0, 1, 32'hFFFFABCD);
        idle(LAT);
        check("t4_vld", chk_vld, 1);
        check("t4_err", chk_err, 0);
        check("t4_msk", head.msk, 32'h0000FFFF);

        // Reads in flight are dropped by reset.
        cycle(1, 1, 0, 0, '0, '0);
        cycle(1, 2, 0, 0, '0, '0);
        cycle(1, 3, 0, 0, '0, '0);
        do_reset();
        idle(LAT + 1);
        check("t5_rd_cnt", rd_cnt, 0);

        // Counter saturation with first failure preserved.
        cycle(0, 0, 1, 3, 32'hC0FFEE00, '1);
        for (int i = 0; i < SAT + 3; i++)
            cycle(1, 3, 0, 0, '0, '0, 32'h10);
        idle(LAT + 1);
        check("t6_err_cnt", err_cnt, SAT);
        check("t6_rd_cnt", rd_cnt, SAT);
        check("t6_faddr", first_err_addr, 3);
        check("t6_fexp", first_err_exp, 32'hC0FFEE00);
        check("t6_fgot", first_err_got, 32'hC0FFEE10);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] b, f;
            if (i == 1500) do_reset();
            b = ($urandom % 3 == 0) ? '1 : DW'($urandom);
            f = ($urandom % 8 == 0) ? (DW'(1) << ($urandom % DW)) : '0;
            cycle($urandom % 2, $urandom_range(0, WORDS - 1),
                  $urandom % 2, $urandom_range(0, WORDS - 1),
                  DW'($urandom), b, f);
        end
        idle(LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
